jump_ctrl: RTL and testbench

JUMP_CTRL -- requirements
Module: jump_ctrl

---
 rtl/game_pkg.sv | 18 +
 rtl/frame_divider.sv | 27 ++
 rtl/jump_ctrl.sv | 144 ++++++++++++++
 tb/tb_jump_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared key codes and jump FSM state encoding
package game_pkg;

   localparam logic [7:0] JUMP_KEY  = 8'h1A;
   localparam logic [7:0] LEFT_KEY  = 8'h04;
   localparam logic [7:0] RIGHT_KEY = 8'h07;

   // Vertical speed is kept narrow internally and sign-extended at the port.
   localparam int VY_W = 8;

   typedef enum logic [1:0] {
      GROUNDED = 2'd0,
      RISING   = 2'd1,
      APEX     = 2'd2,
      FALLING  = 2'd3
   } jump_state_t;

endpackage

// File: rtl/frame_divider.sv
// rtl/frame_divider.sv - wrapping frame counter with load, enable and terminal count
module frame_divider #(
   parameter int PERIOD = 3
) (
   input  logic frame_clk,
   input  logic Reset,
   input  logic load,
   input  logic enable,
   output logic tc
);

   localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge frame_clk) begin
      if (Reset || load) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
      end
   end

   assign tc = (cnt == LAST);

endmodule

// File: rtl/jump_ctrl.sv
// rtl/jump_ctrl.sv - per-frame walk and jump motion controller for the player character
module jump_ctrl #(
   parameter logic [7:0] JUMP_KEY    = game_pkg::JUMP_KEY,
   parameter logic [7:0] LEFT_KEY    = game_pkg::LEFT_KEY,
   parameter logic [7:0] RIGHT_KEY   = game_pkg::RIGHT_KEY,
   parameter int         WALK_STEP   = 3,
   parameter int         JUMP_V0     = 6,
   parameter int         GRAV_PERIOD = 3,
   parameter int         MAX_FALL    = 4,
   parameter int         APEX_FRAMES = 2
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic [2:0] wLeft,
   input  logic [2:0] wRight,
   input  logic [2:0] wTop,
   input  logic [2:0] wBottom,
   input  logic       gate_block,
   output logic [9:0] x_motion,
   output logic [9:0] y_motion,
   output logic [1:0] state,
   output logic       airborne
);

   import game_pkg::*;

   localparam logic signed [VY_W-1:0] VY_LAUNCH = VY_W'(-JUMP_V0);
   localparam logic signed [VY_W-1:0] VY_ONE    = VY_W'(1);
   localparam logic signed [VY_W-1:0] VY_MAX    = VY_W'(MAX_FALL);

   jump_state_t            st;
   logic signed [VY_W-1:0] vy;
   logic signed [VY_W-1:0] vy_inc;
   logic                   armed;
   logic                   launch;
   logic                   g_en;
   logic                   g_tc;
   logic                   a_tc;

   always_comb begin
      launch = (st == GROUNDED) && (keycode == JUMP_KEY) && armed &&
               (wTop == 3'd1) && !gate_block;
      // Gravity only runs while rising freely or falling freely; any other frame restarts it.
      g_en   = ((st == RISING) && (wTop == 3'd1)) ||
               ((st == FALLING) && (wBottom != 3'd0));
      vy_inc = vy + VY_ONE;
   end

   frame_divider #(.PERIOD(GRAV_PERIOD)) u_gcnt (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (!g_en),
      .enable    (g_en),
      .tc        (g_tc)
   );

   frame_divider #(.PERIOD(APEX_FRAMES)) u_acnt (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .load      (st != APEX),
      .enable    (st == APEX),
      .tc        (a_tc)
   );

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         st       <= GROUNDED;
         vy       <= '0;
         armed    <= 1'b0;
         x_motion <= '0;
         airborne <= 1'b0;
      end else begin
         if (keycode == JUMP_KEY)
            x_motion <= '0;
         else if ((keycode == LEFT_KEY) && (wLeft == 3'd1))
            x_motion <= 10'(-WALK_STEP);
         else if ((keycode == RIGHT_KEY) && (wRight == 3'd1))
            x_motion <= 10'(WALK_STEP);
         else
            x_motion <= '0;

         // Re-arm only once the jump key is released, so a held key cannot bounce.
         if (launch)
            armed <= 1'b0;
         else if (keycode != JUMP_KEY)
            armed <= 1'b1;

         case (st)
            GROUNDED: begin
               if (launch) begin
                  st       <= RISING;
                  vy       <= VY_LAUNCH;
                  airborne <= 1'b1;
               end else if (wBottom != 3'd0) begin
                  st       <= FALLING;
                  vy       <= VY_ONE;
                  airborne <= 1'b1;
               end else begin
                  vy <= '0;
               end
            end
            RISING: begin
               if (wTop != 3'd1) begin
                  st <= FALLING;
                  vy <= '0;
               end else if (g_tc) begin
                  if (vy_inc == '0) begin
                     st <= APEX;
                     vy <= '0;
                  end else begin
                     vy <= vy_inc;
                  end
               end
            end
            APEX: begin
               if (a_tc) begin
                  st <= FALLING;
                  vy <= VY_ONE;
               end else begin
                  vy <= '0;
               end
            end
            FALLING: begin
               if (wBottom == 3'd0) begin
                  st       <= GROUNDED;
                  vy       <= '0;
                  airborne <= 1'b0;
               end else if (g_tc && (vy < VY_MAX)) begin
                  vy <= vy_inc;
               end
            end
            default: begin
               st <= GROUNDED;
               vy <= '0;
            end
         endcase
      end
   end

   assign y_motion = {{(10-VY_W){vy[VY_W-1]}}, vy};
   assign state    = st;

endmodule

// File: tb/tb_jump_ctrl.sv
// tb/tb_jump_ctrl.sv - scoreboard bench for jump_ctrl against a frame-level physics model
module tb_jump_ctrl;

   localparam int JK = 8'h1A;
   localparam int LK = 8'h04;
   localparam int RK = 8'h07;
   localparam int WS = 3;
   localparam int V0 = 6;
   localparam int GP = 3;
   localparam int MF = 4;
   localparam int AF = 2;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic [7:0] keycode;
   logic [2:0] wLeft, wRight, wTop, wBottom;
   logic       gate_block;
   logic [9:0] x_motion, y_motion;
   logic [1:0] state;
   logic       airborne;

   jump_ctrl dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .wLeft      (wLeft),
      .wRight     (wRight),
      .wTop       (wTop),
      .wBottom    (wBottom),
      .gate_block (gate_block),
      .x_motion   (x_motion),
      .y_motion   (y_motion),
      .state      (state),
      .airborne   (airborne)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [1:0] st;
      logic       air;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   vectors = 0;
   int   miscompares = 0;
   bit   cap_on = 1'b0;
   int   ycap[$];

   // Physics model: phase, speed, frames spent in the current phase.
   int m_st = 0, m_vy = 0, m_f = 0, m_a = 0, m_x = 0;
   bit m_armed = 1'b0;

   task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  nm, $signed(act), act, $signed(expv), expv, $time);
      end
   endtask

   task automatic model(input bit rst, input int key, input int wl, input int wr,
                        input int wt, input int wb, input bit gate);
      bit launch;
      if (rst) begin
         m_st = 0; m_vy = 0; m_f = 0; m_a = 0; m_x = 0; m_armed = 1'b0;
         return;
      end
      if (key == JK)                  m_x = 0;
      else if (key == LK && wl == 1)  m_x = -WS;
      else if (key == RK && wr == 1)  m_x = WS;
      else                            m_x = 0;
      launch = (m_st == 0) && (key == JK) && m_armed && (wt == 1) && !gate;
      if (launch)          m_armed = 1'b0;
      else if (key != JK)  m_armed = 1'b1;
      case (m_st)
         0: begin
            if (launch) begin
               m_st = 1; m_vy = -V0; m_f = 0;
            end else if (wb != 0) begin
               m_st = 3; m_vy = 1; m_f = 0;
            end else m_vy = 0;
         end
         1: begin
            if (wt != 1) begin
               m_st = 3; m_vy = 0; m_f = 0;
            end else begin
               m_f++;
               if (m_f % GP == 0) begin
                  m_vy++;
                  if (m_vy == 0) begin m_st = 2; m_a = 0; end
               end
            end
         end
         2: begin
            m_a++;
            if (m_a == AF) begin m_st = 3; m_vy = 1; m_f = 0; end
            else m_vy = 0;
         end
         default: begin
            if (wb == 0) begin
               m_st = 0; m_vy = 0;
            end else begin
               m_f++;
               if (m_f % GP == 0 && m_vy < MF) m_vy++;
            end
         end
      endcase
   endtask

   task automatic step(input bit rst, input logic [7:0] key, input logic [2:0] wl,
                       input logic [2:0] wr, input logic [2:0] wt, input logic [2:0] wb,
                       input bit gate);
      exp_t ex;
      Reset = rst; keycode = key; wLeft = wl; wRight = wr; wTop = wt; wBottom = wb;
      gate_block = gate;
      model(rst, int'(key), int'(wl), int'(wr), int'(wt), int'(wb), gate);
      ex.x = 10'(m_x); ex.y = 10'(m_vy); ex.st = 2'(m_st); ex.air = (m_st != 0);
      sb.push_back(ex);
      @(posedge frame_clk);
      @(negedge frame_clk);
      #1;
   endtask

   task automatic check_cap(input string nm, input int expq[$]);
      chk({nm, "_len"}, 10'(ycap.size()), 10'(expq.size()));
      for (int i = 0; i < expq.size() && i < ycap.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), 10'(ycap[i]), 10'(expq[i]));
      ycap.delete();
   endtask

   always @(negedge frame_clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("x_motion", x_motion, mon_e.x);
         chk("y_motion", y_motion, mon_e.y);
         chk("state",    10'(state), 10'(mon_e.st));
         chk("airborne", 10'(airborne), 10'(mon_e.air));
         if (cap_on) ycap.push_back(int'($signed(y_motion)));
      end
   end

   initial begin
      int prof[$];
      int ceil_prof[$];
      logic [7:0] k;
      logic [2:0] wl, wr, wt, wb;
      bit g;
      int r;

      for (int v = -V0; v < 0; v++) repeat (GP) prof.push_back(v);
      repeat (AF) prof.push_back(0);
      prof.push_back(1);
      ceil_prof = '{0, 0, 0, 1, 1};

      step(1, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      step(1, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);

      // Full jump, then keep the key held through landing.
      step(0, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      cap_on = 1'b1;
      repeat (21) step(0, 8'h1A, 3'd0, 3'd0, 3'd1, 3'd0, 0);
      cap_on = 1'b0;
      check_cap("jump_profile", prof);
      repeat (5) step(0, 8'h1A, 3'd0, 3'd0, 3'd1, 3'd0, 0);

      // Release, relaunch, then bump the ceiling at vy=-4 while steering right.
      step(0, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      step(0, 8'h1A, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      repeat (6) step(0, 8'h1A, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      cap_on = 1'b1;
      step(0, 8'h07, 3'd1, 3'd1, 3'd0, 3'd1, 0);
      repeat (4) step(0, 8'h07, 3'd1, 3'd1, 3'd1, 3'd1, 0);
      cap_on = 1'b0;
      check_cap("ceiling", ceil_prof);

      // Walk off a ledge to terminal velocity.
      step(1, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      repeat (20) step(0, 8'h04, 3'd1, 3'd1, 3'd1, 3'd1, 0);

      // Gate overhead blocks the launch.
      step(1, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      step(0, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      repeat (4) step(0, 8'h1A, 3'd1, 3'd1, 3'd1, 3'd0, 1);

      // Reset while rising.
      step(0, 8'h00, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      repeat (3) step(0, 8'h1A, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      step(1, 8'h07, 3'd1, 3'd1, 3'd1, 3'd0, 0);
      step(0, 8'h07, 3'd1, 3'd1, 3'd1, 3'd0, 0);

      k = 8'h00; wl = 3'd1; wr = 3'd1; wt = 3'd1; wb = 3'd0; g = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 4);
            case (r)
               0: k = 8'h00;
               1: k = 8'h1A;
               2: k = 8'h04;
               3: k = 8'h07;
               default: k = 8'($urandom);
            endcase
            wl = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom);
            wr = ($urandom_range(0, 9) < 7) ? 3'd1 : 3'($urandom);
            wt = ($urandom_range(0, 19) < 17) ? 3'd1 : 3'($urandom);
            wb = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom);
            g  = ($urandom_range(0, 19) < 3);
         end
         step(($urandom_range(0, 99) == 0), k, wl, wr, wt, wb, g);
      end

      repeat (5) begin
         if (sb.size() != 0) @(negedge frame_clk);
      end
      chk("scoreboard_drained", 10'(sb.size()), 10'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
